// File: rtl/iv_keystream_ctrl_if.sv
// iv_keystream_ctrl_if: control, keystream and core-side signals of the keystream sequencer
interface iv_keystream_ctrl_if;
  logic start;
  logic abort;
  logic mode;
  logic [15:0] nblocks;
  logic [127:0] key_in;
  logic [127:0] iv_in;
  logic busy;
  logic [127:0] ks_data;
  logic ks_valid;
  logic ks_ready;
  logic ks_last;
  logic timeout;
  logic core_ld;
  logic [127:0] core_key;
  logic [127:0] core_iv;
  logic core_done;
  logic [127:0] core_iv_out;
  modport master (
    output start, abort, mode, nblocks, key_in, iv_in, ks_ready, core_done, core_iv_out,
    input busy, ks_data, ks_valid, ks_last, timeout, core_ld, core_key, core_iv
  );
  modport slave (
    input start, abort, mode, nblocks, key_in, iv_in, ks_ready, core_done, core_iv_out,
    output busy, ks_data, ks_valid, ks_last, timeout, core_ld, core_key, core_iv
  );
endinterface

// File: rtl/iv_keystream_ctrl.sv
// iv_keystream_ctrl: sequences an AES IV core to emit OFB/CTR keystream blocks through a one-entry buffer
module iv_keystream_ctrl #(
  parameter int CTR_W = 32,
  parameter int TIMEOUT = 31
) (
  input logic clk,
  input logic rst_n,
  iv_keystream_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;
  localparam logic [127:0] CTR_MASK = CTR_W >= 128 ? {128{1'b1}} : (128'(1) << CTR_W) - 128'(1);
  localparam logic [7:0] WD_MAX = 8'(TIMEOUT - 1);
  state_t state, state_nx;
  logic [127:0] key_q, iv_q, data_q, iv_ctr;
  logic mode_q, valid_q, last_q, busy_q, tmo_q;
  logic [15:0] rem_q;
  logic [7:0] wd_q;
  logic start_acc, buf_free, hs, ld, expire;
  always_comb begin
    start_acc = state == IDLE && bus.start && bus.nblocks != 16'd0;
    buf_free = !valid_q || bus.ks_ready;
    hs = valid_q && bus.ks_ready;
    ld = state == ISSUE && buf_free && !bus.abort;
    expire = state == WAIT && !bus.core_done && wd_q == WD_MAX;
    iv_ctr = (iv_q & ~CTR_MASK) | ((iv_q + 128'(1)) & CTR_MASK);
    state_nx = bus.abort ? IDLE :
      state == IDLE ? (start_acc ? ISSUE : IDLE) :
      state == ISSUE ? (buf_free ? WAIT : ISSUE) :
      state == WAIT ? (bus.core_done ? (rem_q == 16'd1 ? IDLE : ISSUE) : (expire ? ERR : WAIT)) :
      IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_q <= '0;
      iv_q <= '0;
      data_q <= '0;
      mode_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      tmo_q <= 1'b0;
      rem_q <= '0;
      wd_q <= '0;
    end else if (bus.abort) begin
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (start_acc) begin
        key_q <= bus.key_in;
        iv_q <= bus.iv_in;
        mode_q <= bus.mode;
        rem_q <= bus.nblocks;
        tmo_q <= 1'b0;
        busy_q <= 1'b1;
      end else if (state == IDLE && hs && last_q) busy_q <= 1'b0;
      if (hs) begin
        valid_q <= 1'b0;
        last_q <= 1'b0;
      end
      if (ld) wd_q <= '0;
      // the core does not hold its result, so it is captured in the done cycle only
      if (state == WAIT) begin
        if (bus.core_done) begin
          data_q <= bus.core_iv_out;
          valid_q <= 1'b1;
          last_q <= rem_q == 16'd1;
          rem_q <= rem_q - 16'd1;
          iv_q <= mode_q ? iv_ctr : bus.core_iv_out;
        end else if (expire) begin
          tmo_q <= 1'b1;
          busy_q <= 1'b0;
          valid_q <= 1'b0;
        end else wd_q <= wd_q + 8'd1;
      end
    end
  assign bus.busy = busy_q;
  assign bus.ks_data = data_q;
  assign bus.ks_valid = valid_q;
  assign bus.ks_last = last_q;
  assign bus.timeout = tmo_q;
  assign bus.core_ld = ld;
  assign bus.core_key = key_q;
  assign bus.core_iv = iv_q;
endmodule

// File: doc/iv_keystream_ctrl.md
Name: iv_keystream_ctrl

Overview:
Sequencer that drives one single-block AES-128 IV encryption core to produce a stream of keystream blocks in OFB or CTR mode.
- Latches key, seed IV, mode and block count on start.
- Issues one load pulse per block and captures the core result when the core signals done.
- Computes the next IV (OFB: feedback of the output; CTR: counter increment).
- Presents each block to a downstream consumer through a one-entry valid/ready buffer, with a done-timeout watchdog.

Parameters:
CTR_W, 32, number of low IV bits incremented in CTR mode (1..128); upper 128-CTR_W bits are held constant.
TIMEOUT, 31, maximum cycles spent in WAIT without core_done before an error is raised (8-bit counter).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; accepted only in IDLE with nblocks!=0
abort  in  1  return to IDLE from any state
mode  in  1  0=OFB, 1=CTR
nblocks  in  16  number of blocks to generate
key_in  in  128  AES key, sampled on accepted start
iv_in  in  128  seed IV, sampled on accepted start
busy  out  1  high from accepted start until final handshake, abort or error
ks_data  out  128  keystream block
ks_valid  out  1  ks_data valid
ks_ready  in  1  consumer accepts; transfer when ks_valid&ks_ready
ks_last  out  1  qualifies the final block of the run (valid only with ks_valid)
timeout  out  1  sticky error flag; cleared by the next accepted start or by reset
core_ld  out  1  load pulse to the core
core_key  out  128  key to the core; registered, constant for the whole run
core_iv  out  128  IV to the core; registered, stable whenever core_ld=1
core_done  in  1  core completion pulse
core_iv_out  in  128  core result; sampled only in the cycle core_done=1

Behaviour:
- Reset values: all outputs 0; state=IDLE; internal counters 0.
- States: IDLE, ISSUE, WAIT, ERR.
- IDLE:
  - start & nblocks!=0 → latch key, iv_in, mode, rem=nblocks; clear timeout; busy=1; go to ISSUE.
  - start with nblocks=0 is ignored: no core_ld, busy stays 0.
  - start while not IDLE is ignored.
- ISSUE:
  - If the buffer is free this cycle (!ks_valid | ks_ready): core_ld=1 for exactly this cycle, clear the watchdog, go to WAIT.
  - Otherwise hold with core_ld=0 and wait for the buffer to free.
  - Rationale: core_iv_out is not held by the core, so a block is never launched while an unread block occupies the buffer.
- WAIT, on core_done:
  - Capture ks_data=core_iv_out; ks_valid=1 from the next cycle; rem decrements.
  - ks_last=1 when rem was 1.
  - Next core_iv: OFB → core_iv_out; CTR → low CTR_W bits of core_iv + 1, wrapping all-ones→0, upper bits unchanged.
  - rem>1 → go to ISSUE. rem==1 → go to IDLE.
- busy deasserts in the cycle after the final ks_valid&ks_ready handshake. ks_valid remains set in IDLE until that handshake.
- Watchdog:
  - Increments each WAIT cycle without core_done.
  - When it reaches TIMEOUT: go to ERR with timeout=1, busy=0, ks_valid=0.
  - ERR exits to IDLE on the next cycle; the timeout flag persists.
- Buffer: ks_data and ks_last are stable while ks_valid & !ks_ready. Deasserting ks_ready never drops ks_valid.
- abort (highest priority after reset), any state, next cycle:
  - state=IDLE; busy, ks_valid, ks_last, core_ld = 0.
  - A core_done arriving later is ignored in IDLE.
- core_done outside WAIT is ignored.
- Simultaneous events in WAIT:
  - core_done in the same cycle the watchdog expires: done wins.
  - abort together with start: abort wins.
- Reset asserted mid-run: immediate return to reset values, independent of the clock.
- Latency: accepted start at edge T → core_ld high in cycle T+1. core_done at cycle D → ks_valid high at D+1. Next core_ld earliest at D+1 if the consumer keeps ks_ready=1.

Test Plan:
- FIPS-197 single block, OFB, nblocks=1: key=000102..0f, iv_in=00112233445566778899aabbccddeeff, behavioural core model. Required: exactly one core_ld; ks_data=69c4e0d86a7b0430d8cdb78070b4c55a; ks_valid=ks_last=1; busy falls after the handshake.
- OFB, nblocks=3, ks_ready=1: core_iv for block n+1 equals ks_data of block n. Exactly 3 core_ld pulses; ks_last only on the third block.
- CTR wrap, CTR_W=32, iv_in low word ffffffff, nblocks=2: second core_iv low word 00000000, upper 96 bits unchanged.
- Backpressure: ks_ready=0 for 40 cycles after block 1 of nblocks=2. Required: no second core_ld and ks_data stable for those cycles; core_ld exactly in the cycle ks_ready rises.
- Timeout: core_done tied 0. Required: timeout=1 after TIMEOUT WAIT cycles, one core_ld total, return to IDLE; next start clears timeout.
- start with nblocks=0 → no core_ld, busy=0. abort mid-WAIT → IDLE next cycle and a late core_done is ignored. rst_n pulsed mid-run → all outputs 0 with no clock edge required.
